// File: rtl/xfer_ctrl_if.sv
// xfer_ctrl_if: bus between the transfer sequencer, memory A, the add/sub
// datapath and memory B. The Abort line exists only when XFER_CTRL_ABORT_EN
// is defined.
//
// Handshake semantics: Start is a level that the sequencer samples only while
// idle (no valid/ready pairing, no queuing). WEB is a single-cycle write
// strobe that qualifies AddrB. Memory B captures the mux result at the end of
// that cycle. Done is a single-cycle completion pulse. Busy is a plain status
// level.
interface xfer_ctrl_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_A_WIDTH = 3,
    parameter int ADDR_B_WIDTH = 2
);
    logic                    Start;
`ifdef XFER_CTRL_ABORT_EN
    logic                    Abort;
`endif
    logic [DATA_WIDTH-1:0]   DataOutA;
    logic [ADDR_A_WIDTH-1:0] AddrA;
    logic [DATA_WIDTH-1:0]   OperandA;
    logic [DATA_WIDTH-1:0]   OperandB;
    logic                    Sign;
    logic                    WEB;
    logic [ADDR_B_WIDTH-1:0] AddrB;
    logic                    Busy;
    logic                    Done;

    // Sequencer side
    modport master (
`ifdef XFER_CTRL_ABORT_EN
        input  Abort,
`endif
        input  Start, DataOutA,
        output AddrA, OperandA, OperandB, Sign, WEB, AddrB, Busy, Done
    );

    // Environment side: memories, datapath, host
    modport slave (
`ifdef XFER_CTRL_ABORT_EN
        output Abort,
`endif
        output Start, DataOutA,
        input  AddrA, OperandA, OperandB, Sign, WEB, AddrB, Busy, Done
    );
endinterface

// File: rtl/xfer_ctrl.sv
// xfer_ctrl: memory-to-memory transfer sequencer.
// For each pair k it reads A[2k] and A[2k+1], presents them as operands, and
// selects SUB when A[2k] >= A[2k+1] (unsigned) and ADD otherwise. It then
// strobes the mux result into B[k]. Each pair takes 5 cycles:
// RD0 -> RD1 -> CAP -> CMP -> WR.
// Optional feature: define XFER_CTRL_ABORT_EN to add the Abort input.
module xfer_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_A_WIDTH = 3,
    parameter int ADDR_B_WIDTH = 2,
    parameter int NUM_PAIRS    = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    xfer_ctrl_if.master xfer,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_CAP  = 3'd3,
        S_CMP  = 3'd4,
        S_WR   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [ADDR_B_WIDTH-1:0] K_LAST = ADDR_B_WIDTH'(NUM_PAIRS - 1);

    state_t                  r_state;
    logic [ADDR_B_WIDTH-1:0] r_k;
    logic [ADDR_A_WIDTH-1:0] r_addr_a;
    logic [ADDR_B_WIDTH-1:0] r_addr_b;
    logic [DATA_WIDTH-1:0]   r_op_a;
    logic [DATA_WIDTH-1:0]   r_op_b;
    logic                    r_sign;
    logic                    r_web;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_abort;
    logic                    w_in_xfer;
    logic [ADDR_B_WIDTH-1:0] w_k_inc;
    logic [ADDR_A_WIDTH-1:0] w_addr_odd;
    logic [ADDR_A_WIDTH-1:0] w_addr_next_even;

`ifdef XFER_CTRL_ABORT_EN
    assign w_abort = xfer.Abort;
`else
    assign w_abort = 1'b0;
`endif

    // Abort only has an effect while a pair is being processed (RD0..WR).
    assign w_in_xfer = (r_state == S_RD0) || (r_state == S_RD1) ||
                       (r_state == S_CAP) || (r_state == S_CMP) ||
                       (r_state == S_WR);

    // AddrA is {k, bit} zero-extended. k never passes NUM_PAIRS-1, so the
    // value always fits.
    assign w_k_inc          = r_k + 1'b1;
    assign w_addr_odd       = ADDR_A_WIDTH'({r_k, 1'b1});
    assign w_addr_next_even = ADDR_A_WIDTH'({w_k_inc, 1'b0});

    // Sequencer FSM: all outputs are registered and set on the edge that
    // enters the state where they must be valid.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_sign   <= 1'b0;
            r_web    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // Strobes default low and are raised for exactly one state.
            r_web  <= 1'b0;
            r_done <= 1'b0;
            if (w_abort && w_in_xfer) begin
                // Any write already in flight (WR cycle) has happened.
                // Quietly drop back to idle with no completion pulse.
                r_state <= S_IDLE;
                r_k     <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (xfer.Start) begin
                            r_state  <= S_RD0;
                            r_k      <= '0;
                            r_addr_a <= '0;
                            r_busy   <= 1'b1;
                        end
                    end
                    S_RD0: begin
                        // A[2k] is being read. Request A[2k+1] next.
                        r_state  <= S_RD1;
                        r_addr_a <= w_addr_odd;
                    end
                    S_RD1: begin
                        // Read data for A[2k] arrives this cycle.
                        r_state <= S_CAP;
                        r_op_a  <= xfer.DataOutA;
                    end
                    S_CAP: begin
                        // Read data for A[2k+1] arrives this cycle.
                        r_state <= S_CMP;
                        r_op_b  <= xfer.DataOutA;
                    end
                    S_CMP: begin
                        // Operands have been stable for a cycle. Pick SUB on
                        // >= (equality included) and open the write.
                        r_state  <= S_WR;
                        r_sign   <= (r_op_a >= r_op_b);
                        r_web    <= 1'b1;
                        r_addr_b <= r_k;
                    end
                    S_WR: begin
                        if (r_k == K_LAST) begin
                            r_state <= S_DONE;
                            r_k     <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= S_RD0;
                            r_k      <= w_k_inc;
                            r_addr_a <= w_addr_next_even;
                        end
                    end
                    S_DONE: begin
                        // Start is deliberately not looked at here.
                        r_state <= S_IDLE;
                        r_k     <= '0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_k     <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign xfer.AddrA    = r_addr_a;
    assign xfer.AddrB    = r_addr_b;
    assign xfer.OperandA = r_op_a;
    assign xfer.OperandB = r_op_b;
    assign xfer.Sign     = r_sign;
    assign xfer.WEB      = r_web;
    assign xfer.Busy     = r_busy;
    assign xfer.Done     = r_done;
    assign o_dbg_state   = r_state;

endmodule
